// File: rtl/jogo_pkg.sv
// Shared definitions for the sequence-memory game control unit.
//   estado_t       : FSM state codes (also exported on db_estado)
//   *_PADRAO       : default timing / lives constants
//   largura()      : counter width for a modulo-N counter, never below 1 bit
package jogo_pkg;

  typedef enum logic [4:0] {
    ST_INICIAL        = 5'd0,
    ST_INICIALIZA     = 5'd1,
    ST_INICIO_RODADA  = 5'd2,
    ST_MOSTRA         = 5'd3,
    ST_ESPERA_MOSTRA  = 5'd4,
    ST_APAGA_MOSTRA   = 5'd5,
    ST_MOSTRA_PROXIMO = 5'd6,
    ST_INICIO_JOGADA  = 5'd7,
    ST_ESPERA_JOGADA  = 5'd8,
    ST_REGISTRA       = 5'd9,
    ST_COMPARA        = 5'd10,
    ST_PROXIMA_JOGADA = 5'd11,
    ST_ESPERA_ESCRITA = 5'd12,
    ST_ESCREVE        = 5'd13,
    ST_PROXIMA_RODADA = 5'd14,
    ST_PERDE_VIDA     = 5'd15,
    ST_ACERTOU        = 5'd16,
    ST_ERROU          = 5'd17,
    ST_TIMEOUT        = 5'd18
  } estado_t;

  localparam int SHOW_ON_PADRAO  = 1000;
  localparam int SHOW_OFF_PADRAO = 500;
  localparam int TIMEOUT_PADRAO  = 5000;
  localparam int LIVES_PADRAO    = 3;

  function automatic int largura(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/jogo_memoria_controle_param_timer.sv
// contador_timer: free-running up counter with synchronous clear.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_zera         : clear count (wins over i_conta)
//   i_conta        : increment count
//   o_count        : current count
//   o_fim          : count == N-1
module contador_timer
  import jogo_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_zera,
  input  logic                  i_conta,
  output logic [largura(N)-1:0] o_count,
  output logic                  o_fim
);

  localparam int CW = largura(N);

  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_zera) begin
      r_count <= '0;
    end else if (i_conta) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_count = r_count;
  assign o_fim   = (r_count == CW'(N - 1));

endmodule

// File: rtl/jogo_memoria_controle_param.sv
// jogo_memoria_controle_param: control unit of the Simon-style memory game.
// Shows a growing sequence from RAM, waits for the player to repeat it, and
// optionally lets the player append one item per round (modo=1). A miss
// (wrong press or timeout) costs one life and replays the current round.
//   clock, reset       : rising-edge clock, asynchronous active-low reset
//   iniciar            : start / restart (only honoured in INICIAL and terminal states)
//   jogada_feita       : one-cycle press pulse; jogada_correta : comparator result
//   nivel_jogadas      : selects last round DEPTH/2-1 or DEPTH-1
//   nivel_tempo        : selects answer timeout TIMEOUT or TIMEOUT/2
//   modo               : 0 fixed sequence, 1 player extends sequence
//   endereco, rodada   : RAM address and current round
//   zeraR, registraR   : button register control; escreveM : RAM write strobe
//   ativa_leds, vez_jogador, ganhou, perdeu, pronto, db_timeout : status
//   vidas              : lives remaining; db_estado : state code
module jogo_memoria_controle_param
  import jogo_pkg::*;
#(
  parameter int ADDR_W   = 4,
  parameter int SHOW_ON  = SHOW_ON_PADRAO,
  parameter int SHOW_OFF = SHOW_OFF_PADRAO,
  parameter int TIMEOUT  = TIMEOUT_PADRAO,
  parameter int LIVES    = LIVES_PADRAO
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         iniciar,
  input  logic                         jogada_feita,
  input  logic                         jogada_correta,
  input  logic                         nivel_jogadas,
  input  logic                         nivel_tempo,
  input  logic                         modo,
  output logic [ADDR_W-1:0]            endereco,
  output logic [ADDR_W-1:0]            rodada,
  output logic                         zeraR,
  output logic                         registraR,
  output logic                         escreveM,
  output logic                         ativa_leds,
  output logic                         vez_jogador,
  output logic                         ganhou,
  output logic                         perdeu,
  output logic                         pronto,
  output logic                         db_timeout,
  output logic [$clog2(LIVES+1)-1:0]   vidas,
  output logic [4:0]                   db_estado
);

  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int LW     = $clog2(LIVES + 1);
  localparam int SHOW_N = (SHOW_ON > SHOW_OFF) ? SHOW_ON : SHOW_OFF;
  localparam int SW     = largura(SHOW_N);
  localparam int TW     = largura(TIMEOUT);

  localparam logic [SW-1:0]     SHOW_ON_FIM  = SW'(SHOW_ON - 1);
  localparam logic [SW-1:0]     SHOW_OFF_FIM = SW'(SHOW_OFF - 1);
  localparam logic [TW-1:0]     TMO_MEIO_FIM = TW'(TIMEOUT / 2 - 1);
  localparam logic [ADDR_W-1:0] ULTIMA_CURTA = ADDR_W'(DEPTH / 2 - 1);
  localparam logic [ADDR_W-1:0] ULTIMA_LONGA = ADDR_W'(DEPTH - 1);
  localparam logic [LW-1:0]     VIDAS_INI    = LW'(LIVES);

  estado_t           r_estado;
  estado_t           w_prox;
  logic [ADDR_W-1:0] r_endereco;
  logic [ADDR_W-1:0] r_rodada;
  logic [LW-1:0]     r_vidas;
  logic              r_modo;
  logic              r_por_timeout;

  logic [SW-1:0]     w_show_cnt;
  logic              w_show_fim;
  logic              w_show_zera;
  logic              w_show_conta;
  logic              w_fim_on;
  logic              w_fim_off;

  logic [TW-1:0]     w_tmo_cnt;
  logic              w_tmo_fim;
  logic              w_tmo_zera;
  logic              w_tmo_conta;
  logic              w_tempo_esgotado;

  logic [ADDR_W-1:0] w_ultima;

  // One shared timer serves both the lit and the blank phase; the shared
  // terminal flag is reused when a phase uses the full timer length.
  assign w_fim_on  = (SHOW_ON  == SHOW_N) ? w_show_fim : (w_show_cnt == SHOW_ON_FIM);
  assign w_fim_off = (SHOW_OFF == SHOW_N) ? w_show_fim : (w_show_cnt == SHOW_OFF_FIM);

  // Cleared on entry to MOSTRA and again at the lit->blank boundary.
  assign w_show_zera  = (r_estado == ST_MOSTRA) ||
                        ((r_estado == ST_ESPERA_MOSTRA) && w_fim_on);
  assign w_show_conta = (r_estado == ST_ESPERA_MOSTRA) || (r_estado == ST_APAGA_MOSTRA);

  // COMPARA clears the timer so ESPERA_ESCRITA starts from zero.
  assign w_tmo_zera  = (r_estado == ST_INICIALIZA)     || (r_estado == ST_INICIO_JOGADA) ||
                       (r_estado == ST_PROXIMA_JOGADA) || (r_estado == ST_COMPARA);
  assign w_tmo_conta = (r_estado == ST_ESPERA_JOGADA)  || (r_estado == ST_ESPERA_ESCRITA);

  assign w_tempo_esgotado = nivel_tempo ? (w_tmo_cnt == TMO_MEIO_FIM) : w_tmo_fim;
  assign w_ultima         = nivel_jogadas ? ULTIMA_LONGA : ULTIMA_CURTA;

  contador_timer #(.N(SHOW_N)) u_timer_mostra (
    .i_clk   (clock),
    .i_rst_n (reset),
    .i_zera  (w_show_zera),
    .i_conta (w_show_conta),
    .o_count (w_show_cnt),
    .o_fim   (w_show_fim)
  );

  contador_timer #(.N(TIMEOUT)) u_timer_resposta (
    .i_clk   (clock),
    .i_rst_n (reset),
    .i_zera  (w_tmo_zera),
    .i_conta (w_tmo_conta),
    .o_count (w_tmo_cnt),
    .o_fim   (w_tmo_fim)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado <= ST_INICIAL;
    end else begin
      r_estado <= w_prox;
    end
  end

  always_comb begin
    w_prox      = r_estado;
    zeraR       = 1'b0;
    registraR   = 1'b0;
    escreveM    = 1'b0;
    ativa_leds  = 1'b0;
    vez_jogador = 1'b0;
    ganhou      = 1'b0;
    perdeu      = 1'b0;
    pronto      = 1'b0;
    db_timeout  = 1'b0;
    case (r_estado)
      ST_INICIAL: begin
        zeraR = 1'b1;
        if (iniciar) w_prox = ST_INICIALIZA;
      end
      ST_INICIALIZA: begin
        zeraR  = 1'b1;
        w_prox = ST_INICIO_RODADA;
      end
      ST_INICIO_RODADA:  w_prox = ST_MOSTRA;
      ST_MOSTRA:         w_prox = ST_ESPERA_MOSTRA;
      ST_ESPERA_MOSTRA: begin
        ativa_leds = 1'b1;
        if (w_fim_on) begin
          w_prox = (r_endereco == r_rodada) ? ST_INICIO_JOGADA : ST_APAGA_MOSTRA;
        end
      end
      ST_APAGA_MOSTRA: begin
        if (w_fim_off) w_prox = ST_MOSTRA_PROXIMO;
      end
      ST_MOSTRA_PROXIMO: w_prox = ST_MOSTRA;
      ST_INICIO_JOGADA:  w_prox = ST_ESPERA_JOGADA;
      ST_ESPERA_JOGADA: begin
        vez_jogador = 1'b1;
        // Timeout wins over a press arriving in the same cycle.
        if (w_tempo_esgotado)  w_prox = ST_PERDE_VIDA;
        else if (jogada_feita) w_prox = ST_REGISTRA;
      end
      ST_REGISTRA: begin
        registraR = 1'b1;
        w_prox    = ST_COMPARA;
      end
      ST_COMPARA: begin
        if (!jogada_correta)              w_prox = ST_PERDE_VIDA;
        else if (r_endereco < r_rodada)   w_prox = ST_PROXIMA_JOGADA;
        else if (r_rodada == w_ultima)    w_prox = ST_ACERTOU;
        else if (r_modo)                  w_prox = ST_ESPERA_ESCRITA;
        else                              w_prox = ST_PROXIMA_RODADA;
      end
      ST_PROXIMA_JOGADA: w_prox = ST_ESPERA_JOGADA;
      ST_ESPERA_ESCRITA: begin
        vez_jogador = 1'b1;
        if (w_tempo_esgotado)  w_prox = ST_PERDE_VIDA;
        else if (jogada_feita) w_prox = ST_ESCREVE;
      end
      ST_ESCREVE: begin
        registraR = 1'b1;
        escreveM  = 1'b1;
        w_prox    = ST_PROXIMA_RODADA;
      end
      ST_PROXIMA_RODADA: w_prox = ST_INICIO_RODADA;
      ST_PERDE_VIDA: begin
        // The decrement lands on this same edge, so one life left means game over.
        if (r_vidas <= LW'(1)) w_prox = r_por_timeout ? ST_TIMEOUT : ST_ERROU;
        else                   w_prox = ST_INICIO_RODADA;
      end
      ST_ACERTOU: begin
        ganhou = 1'b1;
        pronto = 1'b1;
        if (iniciar) w_prox = ST_INICIALIZA;
      end
      ST_ERROU: begin
        perdeu = 1'b1;
        pronto = 1'b1;
        if (iniciar) w_prox = ST_INICIALIZA;
      end
      ST_TIMEOUT: begin
        perdeu     = 1'b1;
        pronto     = 1'b1;
        db_timeout = 1'b1;
        if (iniciar) w_prox = ST_INICIALIZA;
      end
      default: w_prox = ST_INICIAL;
    endcase
  end

  // Address, round, lives and miss-cause registers, updated by the action of
  // the state being left.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_endereco    <= '0;
      r_rodada      <= '0;
      r_vidas       <= VIDAS_INI;
      r_modo        <= 1'b0;
      r_por_timeout <= 1'b0;
    end else begin
      case (r_estado)
        ST_INICIALIZA: begin
          r_rodada      <= '0;
          r_vidas       <= VIDAS_INI;
          r_modo        <= modo;
          r_por_timeout <= 1'b0;
        end
        ST_INICIO_RODADA, ST_INICIO_JOGADA: r_endereco <= '0;
        ST_MOSTRA_PROXIMO, ST_PROXIMA_JOGADA: r_endereco <= r_endereco + ADDR_W'(1);
        ST_ESPERA_JOGADA, ST_ESPERA_ESCRITA: begin
          if (w_tempo_esgotado) r_por_timeout <= 1'b1;
        end
        ST_COMPARA: begin
          r_por_timeout <= 1'b0;
          // The appended item goes right after the last one just repeated.
          if (w_prox == ST_ESPERA_ESCRITA) r_endereco <= r_rodada + ADDR_W'(1);
        end
        ST_PROXIMA_RODADA: r_rodada <= r_rodada + ADDR_W'(1);
        ST_PERDE_VIDA: begin
          if (r_vidas != '0) r_vidas <= r_vidas - LW'(1);
        end
        default: ;
      endcase
    end
  end

  assign endereco  = r_endereco;
  assign rodada    = r_rodada;
  assign vidas     = r_vidas;
  assign db_estado = r_estado;

endmodule

// File: tb/tb_jogo_memoria_controle_param.sv
module tb_jogo_memoria_controle_param;

  localparam logic [4:0] S_INICIAL        = 5'd0;
  localparam logic [4:0] S_INICIALIZA     = 5'd1;
  localparam logic [4:0] S_INICIO_RODADA  = 5'd2;
  localparam logic [4:0] S_MOSTRA         = 5'd3;
  localparam logic [4:0] S_ESPERA_MOSTRA  = 5'd4;
  localparam logic [4:0] S_ESPERA_JOGADA  = 5'd8;
  localparam logic [4:0] S_REGISTRA       = 5'd9;
  localparam logic [4:0] S_ESPERA_ESCRITA = 5'd12;
  localparam logic [4:0] S_ESCREVE        = 5'd13;
  localparam logic [4:0] S_PROXIMA_RODADA = 5'd14;
  localparam logic [4:0] S_PERDE_VIDA     = 5'd15;
  localparam logic [4:0] S_ACERTOU        = 5'd16;
  localparam logic [4:0] S_ERROU          = 5'd17;
  localparam logic [4:0] S_TIMEOUT        = 5'd18;

  logic       clock;
  logic       reset;
  logic       iniciar;
  logic       jogada_feita;
  logic       jogada_correta;
  logic       nivel_jogadas;
  logic       nivel_tempo;
  logic       modo;
  logic [2:0] endereco;
  logic [2:0] rodada;
  logic       zeraR;
  logic       registraR;
  logic       escreveM;
  logic       ativa_leds;
  logic       vez_jogador;
  logic       ganhou;
  logic       perdeu;
  logic       pronto;
  logic       db_timeout;
  logic [1:0] vidas;
  logic [4:0] db_estado;

  int n_vet;
  int n_erro;

  jogo_memoria_controle_param #(
    .ADDR_W(3), .SHOW_ON(4), .SHOW_OFF(2), .TIMEOUT(20), .LIVES(2)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .iniciar        (iniciar),
    .jogada_feita   (jogada_feita),
    .jogada_correta (jogada_correta),
    .nivel_jogadas  (nivel_jogadas),
    .nivel_tempo    (nivel_tempo),
    .modo           (modo),
    .endereco       (endereco),
    .rodada         (rodada),
    .zeraR          (zeraR),
    .registraR      (registraR),
    .escreveM       (escreveM),
    .ativa_leds     (ativa_leds),
    .vez_jogador    (vez_jogador),
    .ganhou         (ganhou),
    .perdeu         (perdeu),
    .pronto         (pronto),
    .db_timeout     (db_timeout),
    .vidas          (vidas),
    .db_estado      (db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Steps until db_estado==e or lim cycles elapse; counts lit cycles on the way.
  task automatic esperar_estado(input logic [4:0] e, input int lim,
                                output int n_ativa, output bit ok);
    n_ativa = 0;
    ok = 1'b0;
    for (int k = 0; k < lim; k++) begin
      if (db_estado == e) begin
        ok = 1'b1;
        break;
      end
      if (ativa_leds) n_ativa++;
      step();
    end
    if (db_estado == e) ok = 1'b1;
  endtask

  task automatic iniciar_jogo();
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
  endtask

  task automatic pressionar(input bit correta);
    jogada_correta = correta;
    jogada_feita   = 1'b1;
    step();
    jogada_feita   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    step();
    n_vet++;
    if (db_estado !== S_INICIAL) begin
      n_erro++; $display("FAIL reset_estado: got %0d expected %0d", db_estado, S_INICIAL);
    end
    n_vet++;
    if ({endereco, rodada} !== 6'd0) begin
      n_erro++; $display("FAIL reset_contadores: got end=%0d rod=%0d expected 0/0", endereco, rodada);
    end
    n_vet++;
    if (vidas !== 2'd2) begin
      n_erro++; $display("FAIL reset_vidas: got %0d expected 2", vidas);
    end
    n_vet++;
    if ({zeraR, registraR, escreveM, ativa_leds, vez_jogador, ganhou, perdeu, pronto, db_timeout} !== 9'b1_0000_0000) begin
      n_erro++;
      $display("FAIL reset_saidas: got %b expected 100000000",
               {zeraR, registraR, escreveM, ativa_leds, vez_jogador, ganhou, perdeu, pronto, db_timeout});
    end
  endtask

  task automatic test_reset_meio();
    int n;
    bit ok;
    iniciar_jogo();
    n_vet++;
    if (db_estado !== S_INICIALIZA) begin
      n_erro++; $display("FAIL inicio_estado: got %0d expected %0d", db_estado, S_INICIALIZA);
    end
    esperar_estado(S_ESPERA_MOSTRA, 20, n, ok);
    step();
    n_vet++;
    if (!ok || ativa_leds !== 1'b1) begin
      n_erro++; $display("FAIL espera_mostra: got ok=%0d ativa=%0d expected 1/1", ok, ativa_leds);
    end
    reset = 1'b0;
    #1;
    n_vet++;
    if ({db_estado, ativa_leds, zeraR, vidas} !== {S_INICIAL, 1'b0, 1'b1, 2'd2}) begin
      n_erro++;
      $display("FAIL reset_assincrono: got est=%0d ativa=%0d zeraR=%0d vidas=%0d expected 0/0/1/2",
               db_estado, ativa_leds, zeraR, vidas);
    end
    @(posedge clock);
    #1;
    reset = 1'b1;
    step();
    n_vet++;
    if (db_estado !== S_INICIAL) begin
      n_erro++; $display("FAIL pos_reset: got %0d expected %0d", db_estado, S_INICIAL);
    end
  endtask

  task automatic test_vitoria();
    int n;
    bit ok;
    modo = 1'b0; nivel_jogadas = 1'b0; nivel_tempo = 1'b0;
    iniciar_jogo();
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i <= r; i++) begin
        esperar_estado(S_ESPERA_JOGADA, 300, n, ok);
        n_vet++;
        if (!ok || (i == 0 && n != 4 * (r + 1))) begin
          n_erro++;
          $display("FAIL mostra_r%0d_i%0d: got ok=%0d lit=%0d expected 1/%0d", r, i, ok, n, (i == 0) ? 4 * (r + 1) : n);
        end
        pressionar(1'b1);
        n_vet++;
        if (db_estado !== S_REGISTRA || endereco !== 3'(i) || rodada !== 3'(r)) begin
          n_erro++;
          $display("FAIL registra_r%0d_i%0d: got est=%0d end=%0d rod=%0d expected 9/%0d/%0d",
                   r, i, db_estado, endereco, rodada, i, r);
        end
      end
    end
    esperar_estado(S_ACERTOU, 10, n, ok);
    step();
    step();
    n_vet++;
    if (!ok || db_estado !== S_ACERTOU || {ganhou, pronto, perdeu, db_timeout} !== 4'b1100 || rodada !== 3'd3) begin
      n_erro++;
      $display("FAIL acertou: got est=%0d gpPt=%b rod=%0d expected 16/1100/3",
               db_estado, {ganhou, pronto, perdeu, db_timeout}, rodada);
    end
  endtask

  task automatic test_vidas();
    int n;
    bit ok;
    iniciar_jogo();
    esperar_estado(S_ESPERA_JOGADA, 300, n, ok);
    pressionar(1'b1);
    esperar_estado(S_ESPERA_JOGADA, 300, n, ok);
    pressionar(1'b1);
    esperar_estado(S_ESPERA_JOGADA, 300, n, ok);
    pressionar(1'b0);
    esperar_estado(S_PERDE_VIDA, 10, n, ok);
    step();
    n_vet++;
    if (!ok || db_estado !== S_INICIO_RODADA || vidas !== 2'd1) begin
      n_erro++; $display("FAIL primeira_falha: got est=%0d vidas=%0d expected 2/1", db_estado, vidas);
    end
    step();
    n_vet++;
    if (db_estado !== S_MOSTRA || endereco !== 3'd0 || rodada !== 3'd1) begin
      n_erro++;
      $display("FAIL replay_inicio: got est=%0d end=%0d rod=%0d expected 3/0/1", db_estado, endereco, rodada);
    end
    esperar_estado(S_ESPERA_JOGADA, 300, n, ok);
    n_vet++;
    if (!ok || n != 8) begin
      n_erro++; $display("FAIL replay_mostra: got ok=%0d lit=%0d expected 1/8", ok, n);
    end
    pressionar(1'b0);
    esperar_estado(S_PERDE_VIDA, 10, n, ok);
    step();
    n_vet++;
    if (!ok || db_estado !== S_ERROU || {perdeu, db_timeout, pronto, ganhou} !== 4'b1010 || vidas !== 2'd0) begin
      n_erro++;
      $display("FAIL errou: got est=%0d pdPg=%b vidas=%0d expected 17/1010/0",
               db_estado, {perdeu, db_timeout, pronto, ganhou}, vidas);
    end
  endtask

  task automatic test_reinicio();
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    n_vet++;
    if (db_estado !== S_INICIALIZA) begin
      n_erro++; $display("FAIL reinicio_estado: got %0d expected %0d", db_estado, S_INICIALIZA);
    end
    step();
    n_vet++;
    if (rodada !== 3'd0 || vidas !== 2'd2) begin
      n_erro++; $display("FAIL reinicio_valores: got rod=%0d vidas=%0d expected 0/2", rodada, vidas);
    end
  endtask

  task automatic test_timeout();
    int n;
    int cnt;
    bit ok;
    nivel_tempo = 1'b1;
    esperar_estado(S_ESPERA_JOGADA, 300, n, ok);
    cnt = 0;
    iniciar = 1'b1;
    while (db_estado == S_ESPERA_JOGADA && cnt < 50) begin
      cnt++;
      step();
      iniciar = 1'b0;
    end
    n_vet++;
    if (!ok || cnt != 10 || db_estado !== S_PERDE_VIDA) begin
      n_erro++; $display("FAIL timeout_ciclos: got ok=%0d ciclos=%0d est=%0d expected 1/10/15", ok, cnt, db_estado);
    end
    step();
    n_vet++;
    if (db_estado !== S_INICIO_RODADA || vidas !== 2'd1) begin
      n_erro++; $display("FAIL timeout_vida: got est=%0d vidas=%0d expected 2/1", db_estado, vidas);
    end
    esperar_estado(S_ESPERA_JOGADA, 300, n, ok);
    for (int k = 0; k < 9; k++) step();
    pressionar(1'b1);
    n_vet++;
    if (!ok || db_estado !== S_PERDE_VIDA) begin
      n_erro++; $display("FAIL timeout_prioridade: got est=%0d expected 15", db_estado);
    end
    step();
    n_vet++;
    if (db_estado !== S_TIMEOUT || {perdeu, db_timeout, pronto, ganhou} !== 4'b1110) begin
      n_erro++;
      $display("FAIL timeout_final: got est=%0d pdPg=%b expected 18/1110", db_estado, {perdeu, db_timeout, pronto, ganhou});
    end
  endtask

  task automatic test_modo_escrita();
    int n;
    bit ok;
    nivel_tempo = 1'b0;
    modo = 1'b1;
    iniciar_jogo();
    step();
    modo = 1'b0;
    esperar_estado(S_ESPERA_JOGADA, 300, n, ok);
    pressionar(1'b1);
    esperar_estado(S_ESPERA_ESCRITA, 10, n, ok);
    n_vet++;
    if (!ok || endereco !== 3'd1 || vez_jogador !== 1'b1) begin
      n_erro++;
      $display("FAIL espera_escrita: got ok=%0d end=%0d vez=%0d expected 1/1/1", ok, endereco, vez_jogador);
    end
    pressionar(1'b1);
    n_vet++;
    if (db_estado !== S_ESCREVE || {escreveM, registraR} !== 2'b11 || endereco !== 3'd1) begin
      n_erro++;
      $display("FAIL escreve: got est=%0d wr=%b end=%0d expected 13/11/1", db_estado, {escreveM, registraR}, endereco);
    end
    step();
    n_vet++;
    if (db_estado !== S_PROXIMA_RODADA || escreveM !== 1'b0) begin
      n_erro++; $display("FAIL escreve_pulso: got est=%0d escreveM=%0d expected 14/0", db_estado, escreveM);
    end
    esperar_estado(S_ESPERA_JOGADA, 300, n, ok);
    n_vet++;
    if (!ok || n != 8 || rodada !== 3'd1) begin
      n_erro++; $display("FAIL modo_rodada1: got ok=%0d lit=%0d rod=%0d expected 1/8/1", ok, n, rodada);
    end
  endtask

  initial begin
    n_vet = 0;
    n_erro = 0;
    reset = 1'b0;
    iniciar = 1'b0;
    jogada_feita = 1'b0;
    jogada_correta = 1'b0;
    nivel_jogadas = 1'b0;
    nivel_tempo = 1'b0;
    modo = 1'b0;
    test_reset();
    test_reset_meio();
    test_vitoria();
    test_vidas();
    test_reinicio();
    test_timeout();
    test_modo_escrita();
    $display("== %0d vectors applied, %0d miscompares ==", n_vet, n_erro);
    $finish;
  end

endmodule
